// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match sequencer: serve/rally/pause/point/over control,
// scoring, rally-length speed selection and winner declaration.
module pong_match_ctrl #(
  parameter int WIN_SCORE = 3,
  parameter int SERVE_DLY = 25_000_000,
  parameter int HITS_FAST = 4,
  parameter int CNT_W     = 25
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       point_l,
  input  logic       point_r,
  input  logic       paddle_hit,
  output logic       ball_hold,
  output logic       ball_en,
  output logic       speed_sel,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RALLY = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DLY - 1);
  localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [3:0]       HITS_VAL   = 4'(HITS_FAST);

  state_t           state_q, state_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       hits_q, hits_d;
  logic             speed_q, speed_d;
  logic             dir_q, dir_d;
  logic [3:0]       sl_q, sl_d, sr_q, sr_d;
  logic             go_q, go_d;
  logic             win_q, win_d;
  logic             hold_q, hold_d;
  logic             en_q, en_d;
  logic             start_rise;

  assign start_rise = start_btn & ~prev_q;

  always_comb begin
    state_d = state_q;
    prev_d  = start_btn;
    cnt_d   = cnt_q;
    hits_d  = hits_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    go_d    = go_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_SERVE;
          sl_d    = '0;
          sr_d    = '0;
          cnt_d   = '0;
          hits_d  = '0;
          speed_d = 1'b0;
        end
      end
      ST_SERVE: begin
        if (cnt_q == SERVE_LAST) state_d = ST_RALLY;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      ST_RALLY: begin
        speed_d = (hits_q == HITS_VAL);
        // A point in the same cycle swallows any hit or pause request.
        if (point_l && point_r) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
          hits_d  = '0;
          speed_d = 1'b0;
        end else if (point_l) begin
          sl_d    = sl_q + 1'b1;
          dir_d   = 1'b1;
          state_d = ST_POINT;
        end else if (point_r) begin
          sr_d    = sr_q + 1'b1;
          dir_d   = 1'b0;
          state_d = ST_POINT;
        end else begin
          if (paddle_hit && hits_q != HITS_VAL) hits_d = hits_q + 1'b1;
          if (pause_btn) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_btn) state_d = ST_RALLY;
      end
      ST_POINT: begin
        if (sl_q == WIN_VAL) begin
          state_d = ST_OVER;
          go_d    = 1'b1;
          win_d   = 1'b0;
        end else if (sr_q == WIN_VAL) begin
          state_d = ST_OVER;
          go_d    = 1'b1;
          win_d   = 1'b1;
        end else begin
          state_d = ST_SERVE;
          cnt_d   = '0;
          hits_d  = '0;
          speed_d = 1'b0;
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          state_d = ST_SERVE;
          sl_d    = '0;
          sr_d    = '0;
          go_d    = 1'b0;
          dir_d   = 1'b1;
          cnt_d   = '0;
          hits_d  = '0;
          speed_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    hold_d = !(state_d == ST_RALLY || state_d == ST_PAUSE);
    en_d   = (state_d == ST_RALLY);
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      hits_q  <= '0;
      speed_q <= 1'b0;
      dir_q   <= 1'b1;
      sl_q    <= '0;
      sr_q    <= '0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
      hold_q  <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      hits_q  <= hits_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      go_q    <= go_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      en_q    <= en_d;
    end
  end

  assign ball_hold = hold_q;
  assign ball_en   = en_q;
  assign speed_sel = speed_q;
  assign serve_dir = dir_q;
  assign score_l   = sl_q;
  assign score_r   = sr_q;
  assign game_over = go_q;
  assign winner    = win_q;
  assign state     = state_q;

endmodule
